// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the 16-bit core. Walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes. One memory port is
// shared between instruction fetch and data access.
//
// Memory handshake: mem_req is raised by the controller and held, together with
// mem_we/mem_byte/iord, until the memory answers with mem_ready in the same
// cycle; the access completes on the first cycle where mem_req && mem_ready.
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] opcode,
   input  logic       alu_lt,
   input  logic       alu_eq,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       mem_byte,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_src,
   output logic       alu_src,
   output logic [1:0] alu_op,
   output logic       reg_write,
   output logic       mem_to_reg,
   output logic       r15_write,
   output logic       halted,
   output logic       fault,
   output logic       illegal_op
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;
   localparam logic [2:0] S_FAULT  = 3'd7;

   localparam logic [3:0] OP_HALT = 4'b0000;
   localparam logic [3:0] OP_JMP  = 4'b0001;
   localparam logic [3:0] OP_BGT  = 4'b0100;
   localparam logic [3:0] OP_BLT  = 4'b0101;
   localparam logic [3:0] OP_BEQ  = 4'b0110;
   localparam logic [3:0] OP_ANDI = 4'b1000;
   localparam logic [3:0] OP_ORI  = 4'b1001;
   localparam logic [3:0] OP_LBU  = 4'b1010;
   localparam logic [3:0] OP_SB   = 4'b1011;
   localparam logic [3:0] OP_LW   = 4'b1100;
   localparam logic [3:0] OP_SW   = 4'b1101;
   localparam logic [3:0] OP_TYPA = 4'b1111;

   localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic [3:0] op_q;
   logic [7:0] wait_cnt;

   logic dec_illegal;
   logic is_load;
   logic is_store;
   logic is_mem;
   logic is_alu;
   logic is_branch;
   logic br_taken;

   // Opcode classification: live opcode for the DECODE decision, latched copy afterwards
   always_comb begin
      dec_illegal = (opcode == 4'b0010) || (opcode == 4'b0011) ||
                    (opcode == 4'b0111) || (opcode == 4'b1110);
      is_load   = (op_q == OP_LBU) || (op_q == OP_LW);
      is_store  = (op_q == OP_SB)  || (op_q == OP_SW);
      is_mem    = is_load || is_store;
      is_alu    = (op_q == OP_TYPA) || (op_q == OP_ANDI) || (op_q == OP_ORI);
      is_branch = (op_q == OP_BLT) || (op_q == OP_BGT) || (op_q == OP_BEQ);
      br_taken  = ((op_q == OP_BLT) && alu_lt) ||
                  ((op_q == OP_BGT) && !alu_lt && !alu_eq) ||
                  ((op_q == OP_BEQ) && alu_eq);
   end

   // Next-state selection; mem_ready on the timeout cycle still completes the access
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   state_nxt = S_FETCH;
         S_FETCH: begin
            if (mem_ready)                 state_nxt = S_DECODE;
            else if (wait_cnt == TIMEOUT)  state_nxt = S_FAULT;
         end
         S_DECODE: begin
            if (opcode == OP_HALT)         state_nxt = S_HALT;
            else if (dec_illegal)          state_nxt = S_FETCH;
            else                           state_nxt = S_EXEC;
         end
         S_EXEC: begin
            if (is_alu)                    state_nxt = S_WB;
            else if (is_mem)               state_nxt = S_MEM;
            else                           state_nxt = S_FETCH;
         end
         S_MEM: begin
            if (mem_ready)                 state_nxt = is_load ? S_WB : S_FETCH;
            else if (wait_cnt == TIMEOUT)  state_nxt = S_FAULT;
         end
         S_WB:     state_nxt = S_FETCH;
         S_HALT:   state_nxt = S_HALT;
         S_FAULT:  state_nxt = S_FAULT;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // State register, opcode latch (taken in DECODE) and memory wait counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         op_q     <= 4'b0000;
         wait_cnt <= 8'd0;
      end else begin
         state <= state_nxt;
         if (state == S_DECODE) op_q <= opcode;
         // Counts only while an access is stalled and stays in the same state;
         // any completion, exit or non-memory state leaves it at zero.
         if (mem_req && !mem_ready && (state_nxt == state))
            wait_cnt <= wait_cnt + 8'd1;
         else
            wait_cnt <= 8'd0;
      end
   end

   // Strobe decode from state and latched opcode
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_byte   = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      alu_src    = 1'b0;
      alu_op     = 2'b00;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      r15_write  = 1'b0;
      halted     = 1'b0;
      fault      = 1'b0;
      illegal_op = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req  = 1'b1;
            ir_write = mem_ready;
            pc_write = mem_ready;
         end
         S_DECODE: illegal_op = dec_illegal;
         S_EXEC: begin
            if (op_q == OP_TYPA) begin
               alu_op = 2'b11;
            end else if (op_q == OP_ANDI) begin
               alu_src = 1'b1;
               alu_op  = 2'b11;
            end else if (op_q == OP_ORI) begin
               alu_src = 1'b1;
               alu_op  = 2'b10;
            end else if (is_mem) begin
               alu_src = 1'b1;
            end else if (is_branch) begin
               alu_op   = 2'b01;
               pc_write = br_taken;
               pc_src   = br_taken;
            end else if (op_q == OP_JMP) begin
               pc_write = 1'b1;
               pc_src   = 1'b1;
            end
         end
         S_MEM: begin
            mem_req  = 1'b1;
            iord     = 1'b1;
            mem_we   = is_store;
            mem_byte = (op_q == OP_LBU) || (op_q == OP_SB);
         end
         S_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = is_load;
            r15_write  = (op_q == OP_TYPA);
         end
         S_HALT:  halted = 1'b1;
         S_FAULT: fault  = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: the driver walks instructions cycle by cycle and
// pushes the expected strobe vector for each cycle; a negedge monitor pops and
// compares against the observed outputs.
module tb_multicycle_ctrl;

   localparam int TMO = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] opcode = 4'b0000;
   logic       alu_lt = 1'b0;
   logic       alu_eq = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_we, mem_byte, iord, ir_write, pc_write, pc_src;
   logic       alu_src, reg_write, mem_to_reg, r15_write, halted, fault, illegal_op;
   logic [1:0] alu_op;

   // Clock generation
   always #5 clk = ~clk;

   multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .alu_lt(alu_lt), .alu_eq(alu_eq),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte),
      .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .alu_src(alu_src), .alu_op(alu_op), .reg_write(reg_write),
      .mem_to_reg(mem_to_reg), .r15_write(r15_write), .halted(halted),
      .fault(fault), .illegal_op(illegal_op)
   );

   // Expected-vector bit weights, MSB to LSB in the order observed below
   localparam logic [15:0] V_REQ  = 16'h8000;
   localparam logic [15:0] V_WE   = 16'h4000;
   localparam logic [15:0] V_BYTE = 16'h2000;
   localparam logic [15:0] V_IORD = 16'h1000;
   localparam logic [15:0] V_IRW  = 16'h0800;
   localparam logic [15:0] V_PCW  = 16'h0400;
   localparam logic [15:0] V_PCS  = 16'h0200;
   localparam logic [15:0] V_ASRC = 16'h0100;
   localparam logic [15:0] V_AOR  = 16'h0080;
   localparam logic [15:0] V_ASUB = 16'h0040;
   localparam logic [15:0] V_AAND = 16'h00C0;
   localparam logic [15:0] V_RW   = 16'h0020;
   localparam logic [15:0] V_M2R  = 16'h0010;
   localparam logic [15:0] V_R15  = 16'h0008;
   localparam logic [15:0] V_HALT = 16'h0004;
   localparam logic [15:0] V_FLT  = 16'h0002;
   localparam logic [15:0] V_ILL  = 16'h0001;

   logic [15:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [15:0] observed();
      return {mem_req, mem_we, mem_byte, iord, ir_write, pc_write, pc_src,
              alu_src, alu_op, reg_write, mem_to_reg, r15_write, halted, fault, illegal_op};
   endfunction

   // Monitor: one expected vector per cycle, compared mid-cycle
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         logic [15:0] e;
         logic [15:0] g;
         e = exp_q.pop_front();
         g = observed();
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL strobes t=%0t got=%b exp=%b (req we byte iord irw pcw pcs asrc aop rw m2r r15 halt flt ill)",
                     $time, g, e);
         end
      end
   end

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model: spec rules as tables ----------------
   function automatic bit is_illegal(input logic [3:0] op);
      return (op == 4'h2) || (op == 4'h3) || (op == 4'h7) || (op == 4'hE);
   endfunction

   function automatic bit is_load_op(input logic [3:0] op);
      return (op == 4'hA) || (op == 4'hC);
   endfunction

   function automatic bit is_store_op(input logic [3:0] op);
      return (op == 4'hB) || (op == 4'hD);
   endfunction

   function automatic logic [15:0] exec_vec(input logic [3:0] op, input logic lt, input logic eq);
      logic [15:0] r;
      bit taken;
      r = 16'h0000;
      taken = 1'b0;
      case (op)
         4'hF: r = V_AAND;
         4'h8: r = V_ASRC | V_AAND;
         4'h9: r = V_ASRC | V_AOR;
         4'hA, 4'hB, 4'hC, 4'hD: r = V_ASRC;
         4'h5: begin taken = lt;          r = V_ASUB; end
         4'h4: begin taken = !lt && !eq;  r = V_ASUB; end
         4'h6: begin taken = eq;          r = V_ASUB; end
         4'h1: taken = 1'b1;
         default: r = 16'h0000;
      endcase
      if (taken) r = r | V_PCW | V_PCS;
      return r;
   endfunction

   function automatic logic [15:0] mem_vec(input logic [3:0] op);
      logic [15:0] r;
      r = V_REQ | V_IORD;
      if (op == 4'hA || op == 4'hB) r = r | V_BYTE;
      if (is_store_op(op)) r = r | V_WE;
      return r;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step(input logic [15:0] e, input logic rdy, input logic lt, input logic eq);
      mem_ready = rdy;
      alu_lt    = lt;
      alu_eq    = eq;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Cycle where memory and compare inputs must not matter
   task automatic step_r(input logic [15:0] e);
      step(e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   task automatic do_fetch(input int fw);
      for (int i = 0; i < fw; i++) begin
         opcode = 4'($urandom_range(0, 15));
         step(V_REQ, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      opcode = 4'($urandom_range(0, 15));
      step(V_REQ | V_IRW | V_PCW, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   // Full instruction from FETCH; halt leaves the DUT in HALT after DECODE
   task automatic run_instr(input logic [3:0] op, input int fw, input int mw,
                            input logic lt, input logic eq);
      logic [15:0] wb;
      do_fetch(fw);
      opcode = op;
      if (op == 4'h0) begin
         step_r(16'h0000);
         return;
      end
      if (is_illegal(op)) begin
         step_r(V_ILL);
         return;
      end
      step_r(16'h0000);
      step(exec_vec(op, lt, eq), 1'($urandom_range(0, 1)), lt, eq);
      if (is_load_op(op) || is_store_op(op)) begin
         for (int i = 0; i < mw; i++) step(mem_vec(op), 1'b0, 1'b0, 1'b0);
         step(mem_vec(op), 1'b1, 1'b0, 1'b0);
      end
      if (op == 4'hF || op == 4'h8 || op == 4'h9 || is_load_op(op)) begin
         wb = V_RW;
         if (is_load_op(op)) wb = wb | V_M2R;
         if (op == 4'hF)     wb = wb | V_R15;
         step_r(wb);
      end
   endtask

   // Reset from a known current-cycle vector; returns with DUT about to enter FETCH
   task automatic do_reset(input logic [15:0] cur);
      rst = 1'b1;
      step_r(cur);
      rst = 1'b0;
      step_r(16'h0000);
   endtask

   task automatic hold_sticky(input logic [15:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         opcode = 4'($urandom_range(0, 15));
         step_r(v);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [3:0] op;
      int fw, mw;
      logic lt, eq;

      // Reset held two edges, then IDLE for one cycle
      rst = 1'b1;
      @(posedge clk);
      #1;
      step_r(16'h0000);
      rst = 1'b0;
      step_r(16'h0000);

      // ANDI with zero waits: FETCH, DECODE, EXEC, WB
      run_instr(4'h8, 0, 0, 1'b0, 1'b0);
      // LW with two memory wait cycles
      run_instr(4'hC, 0, 2, 1'b0, 1'b0);
      // BEQ taken then not taken
      run_instr(4'h6, 0, 0, 1'b0, 1'b1);
      run_instr(4'h6, 0, 0, 1'b0, 1'b0);
      // BLT / BGT both ways, JMP, Type-A, ORI, LBU, SB, SW
      run_instr(4'h5, 0, 0, 1'b1, 1'b0);
      run_instr(4'h5, 1, 0, 1'b0, 1'b1);
      run_instr(4'h4, 0, 0, 1'b0, 1'b0);
      run_instr(4'h4, 0, 0, 1'b0, 1'b1);
      run_instr(4'h1, 2, 0, 1'b0, 1'b0);
      run_instr(4'hF, 0, 0, 1'b0, 1'b0);
      run_instr(4'h9, 0, 0, 1'b0, 1'b0);
      run_instr(4'hA, 1, 1, 1'b0, 1'b0);
      run_instr(4'hB, 0, 3, 1'b0, 1'b0);
      run_instr(4'hD, 0, 0, 1'b0, 1'b0);
      // Illegal opcodes act as NOPs
      run_instr(4'h3, 0, 0, 1'b0, 1'b0);
      run_instr(4'h2, 0, 0, 1'b0, 1'b0);
      run_instr(4'h7, 0, 0, 1'b0, 1'b0);
      run_instr(4'hE, 0, 0, 1'b0, 1'b0);
      // Longest wait that still completes, in FETCH and in MEM
      run_instr(4'hC, TMO, TMO, 1'b0, 1'b0);

      // FETCH timeout: ready stuck low past the limit
      for (int i = 0; i <= TMO; i++) begin
         opcode = 4'($urandom_range(0, 15));
         step(V_REQ, 1'b0, 1'b0, 1'b0);
      end
      hold_sticky(V_FLT, 12);
      do_reset(V_FLT);

      // MEM timeout on a load
      do_fetch(0);
      opcode = 4'hC;
      step_r(16'h0000);
      step(exec_vec(4'hC, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i <= TMO; i++) step(mem_vec(4'hC), 1'b0, 1'b0, 1'b0);
      hold_sticky(V_FLT, 6);
      do_reset(V_FLT);

      // SB with reset asserted while the data access is pending
      do_fetch(0);
      opcode = 4'hB;
      step_r(16'h0000);
      step(exec_vec(4'hB, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0);
      step(mem_vec(4'hB), 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      step(mem_vec(4'hB), 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      step(16'h0000, 1'b0, 1'b0, 1'b0);
      run_instr(4'hD, 0, 1, 1'b0, 1'b0);

      // Randomized instruction stream
      for (int n = 0; n < 300; n++) begin
         op = 4'($urandom_range(1, 15));
         fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TMO)) : 0;
         mw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TMO)) : 0;
         eq = 1'($urandom_range(0, 1));
         lt = eq ? 1'b0 : 1'($urandom_range(0, 1));
         run_instr(op, fw, mw, lt, eq);
      end

      // HALT is sticky until reset
      run_instr(4'h0, 0, 0, 1'b0, 1'b0);
      hold_sticky(V_HALT, 20);
      do_reset(V_HALT);
      run_instr(4'h9, 0, 0, 1'b0, 1'b0);

      // Every pushed expectation must have been consumed
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain left=%0d required=0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
